lpm_walk: RTL



---
 rtl/lpm_walk_if.sv | 41 ++++
 rtl/lpm_walk.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lpm_walk_if.sv
// Request, memory and result buses of the lpm_walk trie walker.
// slave is the walker's view; master is the environment's view.
interface lpm_walk_if #(
   parameter int KEY_W  = 32,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
);
   logic                    request_enter__ENA;
   logic [KEY_W-1:0]        request_enter_x;
   logic [TAG_W-1:0]        request_enter_tag;
   logic                    request_enter__RDY;

   logic                    mem_req__ENA;
   logic [DATA_W-1:0]       mem_req_v;
   logic                    mem_req__RDY;
   logic [DATA_W-1:0]       mem_resValue;
   logic                    mem_resValue__RDY;
   logic                    mem_resAccept__ENA;

   logic                    outQ_enq__ENA;
   logic [TAG_W+DATA_W-1:0] outQ_enq_v;
   logic                    outQ_enq__RDY;

   modport slave (
      input  request_enter__ENA, request_enter_x, request_enter_tag,
      output request_enter__RDY,
      output mem_req__ENA, mem_req_v, mem_resAccept__ENA,
      input  mem_req__RDY, mem_resValue, mem_resValue__RDY,
      output outQ_enq__ENA, outQ_enq_v,
      input  outQ_enq__RDY
   );

   modport master (
      output request_enter__ENA, request_enter_x, request_enter_tag,
      input  request_enter__RDY,
      input  mem_req__ENA, mem_req_v, mem_resAccept__ENA,
      output mem_req__RDY, mem_resValue, mem_resValue__RDY,
      input  outQ_enq__ENA, outQ_enq_v,
      output outQ_enq__RDY
   );
endinterface

// File: rtl/lpm_walk.sv
// Longest-prefix-match multibit trie walker with a shared in-order memory port.
// Define LPM_WALK_STATS_EN to add lookup/miss/recirc counters.
module lpm_walk #(
   parameter int                KEY_W     = 32,
   parameter int                STRIDE    = 8,
   parameter int                LEVELS    = 4,
   parameter int                INFLIGHT  = 4,
   parameter int                TAG_W     = 4,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] ROOT_BASE = '0
) (
   input logic       CLK,
   input logic       RST,
   lpm_walk_if.slave bus
`ifdef LPM_WALK_STATS_EN
   ,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_misses,
   output logic [31:0] stat_recircs
`endif
);
   localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int PTR_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
   localparam int CNT_W = $clog2(INFLIGHT + 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [KEY_W-1:0] key;
   } req_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [KEY_W-1:0] key;
      logic [LVL_W-1:0] level;
   } ctx_t;

   function automatic logic [DATA_W-1:0] idx_of(input logic [KEY_W-1:0] key, input int lvl);
      logic [KEY_W-1:0] sh;
      sh = key << (lvl * STRIDE);
      return DATA_W'(sh[KEY_W-1 -: STRIDE]);
   endfunction

   // input buffer: ib0 is the head, ib1 the second slot
   req_t       ib0_q, ib0_d, ib1_q, ib1_d, ib_new;
   logic [1:0] ib_cnt_q, ib_cnt_d;

   ctx_t             ctx_mem_q [INFLIGHT];
   ctx_t             head, ctx_wr_data;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] ctx_cnt_q, ctx_cnt_d;
   logic             ctx_wr_en, ctx_pop;

   logic              has_head, ctx_full, is_leaf, at_last, resp_v, stale;
   logic              fire_a, fire_b, fire_c, req_rdy, ib_push;
   logic [DATA_W-2:0] result;

   // arbitration between finish (a), recirc (b) and new entry (c)
   always_comb begin
      head     = ctx_mem_q[rd_ptr_q];
      has_head = (ctx_cnt_q != '0);
      ctx_full = (ctx_cnt_q == CNT_W'(INFLIGHT));
      is_leaf  = bus.mem_resValue[0];
      at_last  = (head.level == LVL_W'(LEVELS - 1));
      resp_v   = !RST && bus.mem_resValue__RDY && has_head;
      fire_a   = resp_v && (is_leaf || at_last) && bus.outQ_enq__RDY;
      fire_b   = resp_v && !is_leaf && !at_last && bus.mem_req__RDY;
      fire_c   = !RST && !fire_b && (ib_cnt_q != 2'd0) && (!ctx_full || fire_a)
                 && bus.mem_req__RDY;
      // responses with no context are leftovers from before reset
      stale    = !RST && bus.mem_resValue__RDY && !has_head;
      req_rdy  = !RST && (ib_cnt_q != 2'd2);
      ib_push  = bus.request_enter__ENA && req_rdy;
      result   = is_leaf ? bus.mem_resValue[DATA_W-1:1] : '0;
   end

   always_comb begin
      bus.request_enter__RDY = req_rdy;
      bus.mem_req__ENA       = fire_b || fire_c;
      bus.mem_req_v          = '0;
      if (fire_b)
         bus.mem_req_v = bus.mem_resValue + idx_of(head.key, int'(head.level) + 1);
      else if (fire_c)
         bus.mem_req_v = ROOT_BASE + idx_of(ib0_q.key, 0);
      bus.mem_resAccept__ENA = fire_a || fire_b || stale;
      bus.outQ_enq__ENA      = fire_a;
      bus.outQ_enq_v         = fire_a ? {!is_leaf, head.tag, result} : '0;
   end

   always_comb begin
      ib_new.tag = bus.request_enter_tag;
      ib_new.key = bus.request_enter_x;
      ib0_d      = ib0_q;
      ib1_d      = ib1_q;
      if (fire_c)
         ib0_d = ib1_q;
      if (ib_push) begin
         if ((ib_cnt_q - 2'(fire_c)) == 2'd0) ib0_d = ib_new;
         else                                 ib1_d = ib_new;
      end
      ib_cnt_d = ib_cnt_q - 2'(fire_c) + 2'(ib_push);
   end

   // recirc pops and pushes in one cycle, so it never needs free space
   always_comb begin
      ctx_wr_en         = fire_b || fire_c;
      ctx_pop           = fire_a || fire_b;
      ctx_wr_data.tag   = fire_b ? head.tag : ib0_q.tag;
      ctx_wr_data.key   = fire_b ? head.key : ib0_q.key;
      ctx_wr_data.level = fire_b ? head.level + 1'b1 : '0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (ctx_pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (ctx_wr_en)
         wr_ptr_d = (wr_ptr_q == PTR_W'(INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
      ctx_cnt_d = ctx_cnt_q + CNT_W'(ctx_wr_en) - CNT_W'(ctx_pop);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ib_cnt_q  <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         ctx_cnt_q <= '0;
      end else begin
         ib_cnt_q  <= ib_cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         ctx_cnt_q <= ctx_cnt_d;
      end
      ib0_q <= ib0_d;
      ib1_q <= ib1_d;
      if (ctx_wr_en)
         ctx_mem_q[wr_ptr_q] <= ctx_wr_data;
   end

`ifdef LPM_WALK_STATS_EN
   logic [31:0] lookups_q, lookups_d, misses_q, misses_d, recircs_q, recircs_d;

   always_comb begin
      lookups_d = lookups_q + 32'(fire_c);
      misses_d  = misses_q + 32'(fire_a && !is_leaf);
      recircs_d = recircs_q + 32'(fire_b);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         lookups_q <= '0;
         misses_q  <= '0;
         recircs_q <= '0;
      end else begin
         lookups_q <= lookups_d;
         misses_q  <= misses_d;
         recircs_q <= recircs_d;
      end
   end

   assign stat_lookups = lookups_q;
   assign stat_misses  = misses_q;
   assign stat_recircs = recircs_q;
`else
`endif
endmodule
